// File: rtl/draw_duck.sv
// Sprite overlay: draws a DUCK_W x DUCK_H sprite from an external synchronous
// ROM onto a VGA pixel stream. The stream passes through three register
// stages, and the sprite position is latched once per frame at vblank start.
module draw_duck #(
    parameter int unsigned DUCK_W     = 96,
    parameter int unsigned DUCK_H     = 60,
    parameter logic [11:0] TRANSP_RGB = 12'h0F0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [10:0] duck_x,
    input  logic [10:0] duck_y,
    input  logic        duck_en,
    input  logic        duck_flip,
    output logic [12:0] rom_addr,
    input  logic [11:0] rom_rgb,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam int unsigned CW = 11;
    localparam int unsigned RW = 12;
    localparam int unsigned AW = 13;
    localparam int unsigned SW = 12;

    typedef struct packed {
        logic [CW-1:0] hcount;
        logic [CW-1:0] vcount;
        logic          hsync;
        logic          vsync;
        logic          hblnk;
        logic          vblnk;
        logic [RW-1:0] rgb;
    } vga_t;

    vga_t          vga_in_c;
    vga_t          s1_q, s2_q, s3_q, s3_d;
    logic          vblnk_prev_q;
    logic [CW-1:0] sx_q, sx_d, sy_q, sy_d;
    logic          sen_q, sen_d, sflip_q, sflip_d;
    logic          load_c;
    logic [SW-1:0] h_ext_c, v_ext_c, x_lo_c, x_hi_c, y_lo_c, y_hi_c;
    logic [CW-1:0] col_c, row_c;
    logic          in_box_d, in_box_s1_q, in_box_s2_q;
    logic [AW-1:0] rom_addr_d, rom_addr_q;

    // Shadow position load at vblank start, and stage-1 box test / ROM address
    always_comb begin
        vga_in_c = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};
        load_c   = vblnk_in & ~vblnk_prev_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        sen_d    = sen_q;
        sflip_d  = sflip_q;
        if (load_c) begin
            sx_d    = duck_x;
            sy_d    = duck_y;
            sen_d   = duck_en;
            sflip_d = duck_flip;
        end

        // 12-bit bounds so a sprite hanging off the right/bottom edge clips instead of wrapping
        h_ext_c  = {1'b0, hcount_in};
        v_ext_c  = {1'b0, vcount_in};
        x_lo_c   = {1'b0, sx_q};
        y_lo_c   = {1'b0, sy_q};
        x_hi_c   = x_lo_c + SW'(DUCK_W);
        y_hi_c   = y_lo_c + SW'(DUCK_H);
        in_box_d = sen_q & ~hblnk_in & ~vblnk_in
                 & (h_ext_c >= x_lo_c) & (h_ext_c < x_hi_c)
                 & (v_ext_c >= y_lo_c) & (v_ext_c < y_hi_c);

        col_c = hcount_in - sx_q;
        if (sflip_q) begin
            col_c = CW'(DUCK_W - 1) - col_c;
        end
        row_c = vcount_in - sy_q;

        rom_addr_d = '0;
        if (in_box_d) begin
            rom_addr_d = AW'(32'(row_c) * DUCK_W + 32'(col_c));
        end
    end

    // Stage-3 colour select: opaque sprite pixels override the background
    always_comb begin
        s3_d = s2_q;
        if (in_box_s2_q && (rom_rgb != TRANSP_RGB)) begin
            s3_d.rgb = rom_rgb;
        end
    end

    // Shadow registers and three-stage pixel pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_prev_q <= 1'b0;
            sx_q         <= '0;
            sy_q         <= '0;
            sen_q        <= 1'b0;
            sflip_q      <= 1'b0;
            s1_q         <= '0;
            s2_q         <= '0;
            s3_q         <= '0;
            in_box_s1_q  <= 1'b0;
            in_box_s2_q  <= 1'b0;
            rom_addr_q   <= '0;
        end else begin
            vblnk_prev_q <= vblnk_in;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            sen_q        <= sen_d;
            sflip_q      <= sflip_d;
            s1_q         <= vga_in_c;
            s2_q         <= s1_q;
            s3_q         <= s3_d;
            in_box_s1_q  <= in_box_d;
            in_box_s2_q  <= in_box_s1_q;
            rom_addr_q   <= rom_addr_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign hcount_out = s3_q.hcount;
    assign vcount_out = s3_q.vcount;
    assign hsync_out  = s3_q.hsync;
    assign vsync_out  = s3_q.vsync;
    assign hblnk_out  = s3_q.hblnk;
    assign vblnk_out  = s3_q.vblnk;
    assign rgb_out    = s3_q.rgb;

endmodule

// File: tb/tb_draw_duck.sv
// Scoreboard bench for draw_duck: stimulus pushes expected ROM addresses and
// output pixels into queues; a negedge monitor pops and compares them.
module tb_draw_duck;

    localparam int W = 96;
    localparam int H = 60;
    localparam logic [11:0] TR = 12'h0F0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount_in, vcount_in, duck_x, duck_y;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in, duck_en, duck_flip;
    logic [11:0] rgb_in, rom_rgb, rgb_out;
    logic [12:0] rom_addr;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;

    always #5 clk = ~clk;

    draw_duck #(.DUCK_W(W), .DUCK_H(H), .TRANSP_RGB(TR)) dut (
        .clk(clk), .rst_n(rst_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .duck_x(duck_x), .duck_y(duck_y), .duck_en(duck_en), .duck_flip(duck_flip),
        .rom_addr(rom_addr), .rom_rgb(rom_rgb),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
    );

    // Synchronous ROM fixture with selectable content
    int rom_mode = 0;
    function automatic logic [11:0] rom_fn(input logic [12:0] a, input int mode);
        case (mode)
            0:       return a[11:0];
            1:       return ((a % 5) == 0) ? TR : (a[11:0] ^ 12'h5A5);
            2:       return TR;
            default: return 12'h123;
        endcase
    endfunction
    always @(posedge clk) rom_rgb <= rom_fn(rom_addr, rom_mode);

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic hs, vs, hb, vb;
        logic [11:0] rgb;
    } vga_t;
    typedef struct { int due; logic [12:0] addr; } aexp_t;
    typedef struct { int due; vga_t px; } oexp_t;

    aexp_t aq[$];
    oexp_t oq[$];
    int cyc;
    int n_cmp = 0;
    int n_bad = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against queued expectations when they come due
    always @(negedge clk) begin
        if (rst_n) begin
            while (aq.size() > 0 && aq[0].due <= cyc) begin
                aexp_t e;
                e = aq.pop_front();
                if (e.due != cyc) check("addr_stale", 64'(e.due), 64'(cyc));
                else              check("rom_addr", 64'(rom_addr), 64'(e.addr));
            end
            while (oq.size() > 0 && oq[0].due <= cyc) begin
                oexp_t e;
                vga_t act;
                e = oq.pop_front();
                act = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
                if (e.due != cyc) check("out_stale", 64'(e.due), 64'(cyc));
                else              check("vga_out", 64'(act), 64'(e.px));
            end
        end
    end

    // Reference model state: position latched at each frame start
    int m_sx, m_sy;
    bit m_sen, m_flip, m_prev;

    task automatic model_reset();
        m_sx = 0; m_sy = 0; m_sen = 0; m_flip = 0; m_prev = 0;
    endtask

    // Present one pixel and queue its expected results
    task automatic px(input int h, input int v, input bit hb, input bit vb, input logic [11:0] rgb);
        bit inb;
        int col, row, addr;
        logic [11:0] d;
        vga_t ex;
        @(posedge clk); #1;
        hcount_in = 11'(h); vcount_in = 11'(v);
        hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
        hsync_in = 1'($urandom); vsync_in = 1'($urandom);
        inb = m_sen && !hb && !vb && h >= m_sx && h < m_sx + W && v >= m_sy && v < m_sy + H;
        addr = 0;
        if (inb) begin
            col = h - m_sx;
            if (m_flip) col = W - 1 - col;
            row = v - m_sy;
            addr = (row * W + col) % 8192;
        end
        d = rom_fn(13'(addr), rom_mode);
        ex = {hcount_in, vcount_in, hsync_in, vsync_in, hb, vb, (inb && d != TR) ? d : rgb};
        aq.push_back('{due: cyc + 1, addr: 13'(addr)});
        oq.push_back('{due: cyc + 3, px: ex});
        if (vb && !m_prev) begin
            m_sx = int'(duck_x); m_sy = int'(duck_y); m_sen = duck_en; m_flip = duck_flip;
        end
        m_prev = vb;
    endtask

    task automatic set_duck(input int x, input int y, input bit en, input bit fl);
        @(posedge clk); #1;
        duck_x = 11'(x); duck_y = 11'(y); duck_en = en; duck_flip = fl;
    endtask

    task automatic set_mode(input int m);
        repeat (4) @(posedge clk);
        #1 rom_mode = m;
    endtask

    task automatic frame();
        px(5, 5, 0, 0, 12'h000);
        px(5, 5, 1, 1, 12'h000);
        px(5, 5, 1, 1, 12'h000);
        px(5, 5, 0, 0, 12'h000);
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_addr"}, 64'(rom_addr), 64'd0);
        check({nm, "_vga"}, 64'({hcount_out, vcount_out, hsync_out, vsync_out,
                                 hblnk_out, vblnk_out, rgb_out}), 64'd0);
    endtask

    initial begin
        int vbs;
        rst_n = 1'b0;
        hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0;
        hblnk_in = 0; vblnk_in = 0; rgb_in = '0;
        duck_x = '0; duck_y = '0; duck_en = 0; duck_flip = 0;
        model_reset();
        #3 check_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Address-as-data, unflipped
        set_duck(100, 50, 1, 0);
        frame();
        px(100, 50, 0, 0, 12'hABC);
        px(195, 109, 0, 0, 12'h321);
        px(99, 50, 0, 0, 12'h111);
        px(196, 50, 0, 0, 12'h222);
        px(150, 110, 0, 0, 12'h333);
        px(150, 80, 1, 0, 12'h444);

        // Horizontal mirror
        set_duck(100, 50, 1, 1);
        frame();
        px(100, 50, 0, 0, 12'h555);
        px(195, 50, 0, 0, 12'h666);
        px(120, 70, 0, 0, 12'h777);

        // Transparency handling
        set_mode(2);
        px(130, 60, 0, 0, 12'hABC);
        set_mode(3);
        px(130, 60, 0, 0, 12'hABC);
        set_mode(0);

        // Position change mid-frame takes effect only at next frame
        set_duck(100, 50, 1, 0);
        frame();
        px(100, 50, 0, 0, 12'h010);
        set_duck(300, 50, 1, 0);
        px(100, 50, 0, 0, 12'h020);
        px(300, 50, 0, 0, 12'h030);
        frame();
        px(100, 50, 0, 0, 12'h040);
        px(300, 50, 0, 0, 12'h050);
        px(395, 51, 0, 0, 12'h060);

        // Right-edge clipping without wrap
        set_duck(1000, 50, 1, 0);
        frame();
        px(799, 50, 0, 0, 12'h070);
        px(1000, 50, 0, 0, 12'h080);
        px(1095, 100, 0, 0, 12'h090);
        set_duck(1990, 50, 1, 0);
        frame();
        for (int h = 0; h < 40; h += 13) px(h, 60, 0, 0, 12'h0A0);
        px(95, 60, 0, 0, 12'h0B0);
        px(1989, 60, 0, 0, 12'h0C0);
        px(1990, 60, 0, 0, 12'h0D0);
        px(2047, 109, 0, 0, 12'h0E0);

        // Randomised frames, positions and blanking
        set_mode(1);
        vbs = 0;
        for (int i = 0; i < 3000; i++) begin
            int bx, by, h, v;
            if ($urandom_range(0, 199) == 0) begin
                bx = ($urandom_range(0, 9) == 0) ? $urandom_range(1900, 2047) : $urandom_range(0, 900);
                set_duck(bx, $urandom_range(0, 700), $urandom_range(0, 9) != 0, 1'($urandom));
            end
            if ($urandom_range(0, 49) == 0) vbs = 1 - vbs;
            if ($urandom_range(0, 3) != 0) begin
                h = (int'(duck_x) + $urandom_range(0, W + 20) - 10) & 2047;
                v = (int'(duck_y) + $urandom_range(0, H + 20) - 10) & 2047;
            end else begin
                h = $urandom_range(0, 2047);
                v = $urandom_range(0, 2047);
            end
            px(h, v, $urandom_range(0, 9) == 0, 1'(vbs), 12'($urandom));
        end
        px(5, 5, 0, 0, 12'h000);

        // Asynchronous reset mid-line; sprite suppressed until next frame start
        set_mode(0);
        set_duck(100, 50, 1, 0);
        frame();
        px(110, 55, 0, 0, 12'hF00);
        px(111, 55, 0, 0, 12'hF01);
        @(posedge clk); #1;
        rst_n = 1'b0;
        aq.delete(); oq.delete();
        model_reset();
        #2 check_zero("async_rst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        px(110, 55, 0, 0, 12'hF02);
        px(150, 60, 0, 0, 12'hF03);
        frame();
        px(110, 55, 0, 0, 12'hF04);
        px(150, 60, 0, 0, 12'hF05);

        // Drain with a bounded wait
        for (int i = 0; i < 10 && (aq.size() > 0 || oq.size() > 0); i++) @(posedge clk);
        @(negedge clk); #1;
        if (aq.size() > 0 || oq.size() > 0) check("drain", 64'(aq.size() + oq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/draw_duck.md
DRAW_DUCK -- requirements
Module: draw_duck

Interface
REQ-001 The block SHALL provide parameter DUCK_W, default 96, sprite width in pixels.
REQ-002 The block SHALL provide parameter DUCK_H, default 60, sprite height in pixels.
REQ-003 The block SHALL provide parameter TRANSP_RGB, default 12'h0F0, sprite colour treated as transparent.
REQ-004 The block SHALL have port clk, input, 1, single system clock; all logic runs on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have ports hcount_in and vcount_in, input, 11 each, VGA pixel counters.
REQ-007 The block SHALL have ports hsync_in, vsync_in, hblnk_in and vblnk_in, input, 1 each, VGA timing.
REQ-008 The block SHALL have port rgb_in, input, 12, background pixel.
REQ-009 The block SHALL have ports duck_x and duck_y, input, 11 each, sprite top-left screen position.
REQ-010 The block SHALL have port duck_en, input, 1, draw enable.
REQ-011 The block SHALL have port duck_flip, input, 1, horizontal mirror (duck facing left).
REQ-012 The block SHALL have port rom_addr, output, 13, sprite ROM address.
REQ-013 The block SHALL have port rom_rgb, input, 12, sprite ROM data, valid one clk after rom_addr.
REQ-014 The block SHALL have ports hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out and rgb_out, output, widths matching their inputs, delayed VGA stream.

Function
REQ-015 Shadow registers sx, sy, sen and sflip SHALL load duck_x, duck_y, duck_en and duck_flip only on the cycle where vblnk_in=1 and the registered previous vblnk_in=0; at all other times they SHALL hold.
REQ-016 Stage 1 SHALL register in_box = sen & ~hblnk_in & ~vblnk_in & (hcount_in >= sx) & (hcount_in < sx+DUCK_W) & (vcount_in >= sy) & (vcount_in < sy+DUCK_H).
REQ-017 The comparisons in REQ-016 SHALL use 12-bit sums so that sx+DUCK_W > 2047 does not wrap; pixels past the screen edge are clipped.
REQ-018 Stage 1 SHALL compute col = hcount_in - sx, replaced by DUCK_W-1-col when sflip=1, and row = vcount_in - sy.
REQ-019 Stage 1 SHALL register rom_addr = row*DUCK_W + col, truncated to 13 bits, when in_box is true, and 0 otherwise.
REQ-020 Stage 2 SHALL carry the timing signals, rgb_in and in_box forward one register while the ROM produces rom_rgb.
REQ-021 Stage 3 SHALL drive rgb_out = rom_rgb when in_box_d2=1 and rom_rgb != TRANSP_RGB, and rgb_in_d2 otherwise.
REQ-022 All *_out ports SHALL lag their *_in counterparts by exactly 3 clk cycles, with mutually aligned timing.
REQ-023 The pipeline SHALL accept one pixel per clk with no stalls and no handshake.
REQ-024 A change of duck_x, duck_y, duck_en or duck_flip during active video SHALL NOT affect the current frame.

Reset
REQ-025 While rst_n=0, every output, pipeline register, shadow register and the previous-vblnk register SHALL be 0.
REQ-026 After rst_n deasserts mid-frame, no sprite SHALL be drawn until the first vblnk rising edge after reset has loaded sen=1.
REQ-027 Reset assertion SHALL take effect immediately, without waiting for a clk edge.

Verification
REQ-028 Scenario 1: duck_x=100, duck_y=50, en=1, latched at vblnk; ROM model returns address as data -> the pixel at (100,50) gives rgb_out=0x000 3 cycles later; the pixel at (195,109) gives rom_addr=5759.
REQ-029 Scenario 2: same setup with flip=1 -> the pixel at (100,50) gives rom_addr=95 and (195,50) gives rom_addr=0.
REQ-030 Scenario 3: ROM returns TRANSP_RGB inside the box, rgb_in=0xABC -> rgb_out=0xABC; ROM returns 0x123 -> rgb_out=0x123.
REQ-031 Scenario 4: duck_x changes 100->300 mid-frame -> the sprite stays at 100 for that frame and moves to 300 after the next vblnk rising edge.
REQ-032 Scenario 5: duck_x=1000 on an 800-wide screen, and duck_x=1990 -> no wrap artefacts, no drawing at hcount<DUCK_W, and rom_addr=0 outside the box.
REQ-033 Scenario 6: rst_n pulsed low mid-line -> all outputs go to 0 asynchronously, and no sprite appears until the next vblnk rising edge.
